ook_packet_receiver: RTL and testbench

//  Receive side of the fan-remote OOK link: samples the demodulated envelope from the RF receiver on the 10 MHz ref clock and filters it.

---
 rtl/ook_pkg.sv | 12 +
 rtl/ook_input_filter.sv | 23 ++
 rtl/ook_packet_receiver.sv | 106 ++++++++++
 tb/tb_ook_packet_receiver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ook_pkg.sv
// ook_pkg: shared OOK link constants (packet_generator uses the same ticks) and receiver FSM encoding
package ook_pkg;
    localparam int PACKET_BITS = 40;
    localparam int CNT_W       = 16;
    localparam int SHORT_MIN   = 2000;
    localparam int SHORT_MAX   = 5000;
    localparam int LONG_MIN    = 6000;
    localparam int LONG_MAX    = 10000;
    localparam int LOW_MAX     = 10000;
    localparam int GAP_MIN     = 50000;
    typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} ook_state_t;
endpackage

// File: rtl/ook_input_filter.sv
// ook_input_filter: 2-flop synchroniser plus 3-sample majority vote, filt lags rf_in by 4 clk
module ook_input_filter (
    input  logic clk,
    input  logic reset,
    input  logic rf_in,
    output logic filt
);
    logic s0, s1;
    logic [1:0] sh;
    always_ff @(posedge clk) begin
        if (reset) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            sh   <= '0;
            filt <= 1'b0;
        end else begin
            s0   <= rf_in;
            s1   <= s0;
            sh   <= {sh[0], s1};
            filt <= (s1 & sh[0]) | (s1 & sh[1]) | (sh[0] & sh[1]);
        end
    end
endmodule

// File: rtl/ook_packet_receiver.sv
// ook_packet_receiver: pulse-width OOK decoder delivering fixed-length packets on valid/ready
module ook_packet_receiver #(
    parameter int PACKET_BITS = ook_pkg::PACKET_BITS,
    parameter int CNT_W       = ook_pkg::CNT_W,
    parameter int SHORT_MIN   = ook_pkg::SHORT_MIN,
    parameter int SHORT_MAX   = ook_pkg::SHORT_MAX,
    parameter int LONG_MIN    = ook_pkg::LONG_MIN,
    parameter int LONG_MAX    = ook_pkg::LONG_MAX,
    parameter int LOW_MAX     = ook_pkg::LOW_MAX,
    parameter int GAP_MIN     = ook_pkg::GAP_MIN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rf_in,
    output logic [PACKET_BITS-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   overrun,
    output logic                   busy
);
    import ook_pkg::*;
    localparam int BW = $clog2(PACKET_BITS + 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] S_MIN = CNT_W'(SHORT_MIN);
    localparam logic [CNT_W-1:0] S_MAX = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0] L_MIN = CNT_W'(LONG_MIN);
    localparam logic [CNT_W-1:0] L_MAX = CNT_W'(LONG_MAX);
    localparam logic [CNT_W-1:0] LOW_M = CNT_W'(LOW_MAX);
    localparam logic [CNT_W-1:0] GAP   = CNT_W'(GAP_MIN);
    localparam logic [BW-1:0]    LAST  = BW'(PACKET_BITS - 1);
    localparam logic [BW-1:0]    BIT1  = BW'(1);

    ook_state_t state;
    logic filt, filt_d, flip, is0, is1;
    logic [CNT_W-1:0] cnt;
    logic [BW-1:0] bitcnt;
    logic [PACKET_BITS-1:0] sr, nxt;

    ook_input_filter u_filter (
        .clk   (clk),
        .reset (reset),
        .rf_in (rf_in),
        .filt  (filt)
    );

    // cnt holds the length of the level that just ended whenever flip is high
    assign flip = filt ^ filt_d;
    assign is0  = cnt >= S_MIN && cnt <= S_MAX;
    assign is1  = cnt >= L_MIN && cnt <= L_MAX;
    assign nxt  = {sr[PACKET_BITS-2:0], is1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            filt_d    <= 1'b0;
            cnt       <= '0;
            bitcnt    <= '0;
            sr        <= '0;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            filt_d  <= filt;
            cnt     <= flip ? ONE : (&cnt ? cnt : cnt + ONE);
            overrun <= 1'b0;
            if (pkt_valid && pkt_ready)
                pkt_valid <= 1'b0;
            case (state)
                IDLE:  if (!filt && !filt_d && cnt >= GAP) state <= ARMED;
                ARMED: if (filt) begin
                    state  <= HIGH;
                    busy   <= 1'b1;
                    bitcnt <= '0;
                end
                HIGH: if (filt) begin
                    if (cnt >= L_MAX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end else if (!(is0 || is1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    sr     <= nxt;
                    bitcnt <= bitcnt + BIT1;
                    if (bitcnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!pkt_valid || pkt_ready) begin
                            pkt_data  <= nxt;
                            pkt_valid <= 1'b1;
                        end else
                            overrun <= 1'b1;
                    end else
                        state <= LOW;
                end
                LOW: if (cnt > LOW_M) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (filt)
                    state <= HIGH;
            endcase
        end
    end
endmodule

// File: tb/tb_ook_packet_receiver.sv
// tb_ook_packet_receiver: directed frames on a 1/100 time-scaled receiver with hand-computed expectations
`timescale 1ns/1ps
module tb_ook_packet_receiver;
    localparam int T0 = 30, T1 = 80, TL = 30, GAP = 600;
    localparam logic [39:0] D1 = 40'hA5C30F1234;
    localparam logic [39:0] D2 = 40'h3123456789;
    localparam logic [39:0] DA = 40'h1111111111;
    localparam logic [39:0] DB = 40'h2222222222;
    localparam logic [39:0] DC = 40'h0F0F0F0F0F;

    logic clk = 1'b0, reset = 1'b1, rf_in = 1'b0, pkt_ready = 1'b0;
    logic [39:0] pkt_data;
    logic pkt_valid, overrun, busy;
    int n_checks = 0, n_fail = 0, ov_total = 0;
    int hw_o[40], lw_o[40];

    always #50 clk = ~clk;

    ook_packet_receiver #(
        .PACKET_BITS(40), .CNT_W(16), .SHORT_MIN(20), .SHORT_MAX(50),
        .LONG_MIN(60), .LONG_MAX(100), .LOW_MAX(100), .GAP_MIN(500)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rf_in     (rf_in),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always @(negedge clk) if (overrun) ov_total++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rf_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_ovr();
        foreach (hw_o[i]) begin
            hw_o[i] = 0;
            lw_o[i] = 0;
        end
    endtask

    // sends bits hi..lo MSB first; gl inserts isolated 1-cycle glitches into every level
    task automatic frame(input logic [39:0] d, input int gap, input int hi, input int lo, input bit gl);
        if (gl) begin
            drive(1'b0, gap / 2);
            drive(1'b1, 1);
            drive(1'b0, gap - gap / 2 - 1);
        end else
            drive(1'b0, gap);
        for (int i = hi; i >= lo; i--) begin
            int h, l;
            h = hw_o[i] != 0 ? hw_o[i] : (d[i] ? T1 : T0);
            l = lw_o[i] != 0 ? lw_o[i] : TL;
            if (gl) begin
                drive(1'b1, h / 2);
                drive(1'b0, 1);
                drive(1'b1, h - h / 2 - 1);
            end else
                drive(1'b1, h);
            if (i > 0) begin
                if (gl) begin
                    drive(1'b0, l / 2);
                    drive(1'b1, 1);
                    drive(1'b0, l - l / 2 - 1);
                end else
                    drive(1'b0, l);
            end
        end
        rf_in = 1'b0;
    endtask

    task automatic tail(input string tag, input logic [39:0] exp);
        repeat (4) @(negedge clk);
        check({tag, "_pre"}, pkt_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, pkt_valid, 1);
        check({tag, "_data"}, pkt_data, exp);
        check({tag, "_ovr"}, overrun, 0);
    endtask

    task automatic consume(input logic [39:0] exp);
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        check("ack_valid", pkt_valid, 0);
        check("ack_data", pkt_data, exp);
    endtask

    initial begin
        clear_ovr();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data", pkt_data, 0);
        check("rst_valid", pkt_valid, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);

        frame(D1, GAP, 39, 0, 0);
        repeat (4) @(negedge clk);
        check("t1_pre", pkt_valid, 0);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_valid", pkt_valid, 1);
        check("t1_data", pkt_data, D1);
        check("t1_ovr", overrun, 0);
        check("t1_idle", busy, 0);
        consume(D1);

        hw_o[39] = 20; hw_o[38] = 50; hw_o[37] = 60; hw_o[36] = 100; hw_o[35] = 49;
        lw_o[36] = 100;
        frame(D2, GAP, 39, 0, 0);
        tail("t2", D2);
        consume(D2);
        clear_ovr();

        hw_o[39] = 51;
        frame(D1, GAP, 39, 0, 0);
        drive(1'b0, 6);
        check("t2_abort_valid", pkt_valid, 0);
        check("t2_abort_busy", busy, 0);
        clear_ovr();

        drive(1'b0, GAP);
        drive(1'b1, 50);
        check("t2_long_busy", busy, 1);
        drive(1'b1, 60);
        check("t2_long_abort", busy, 0);
        drive(1'b0, 10);

        frame(D1, GAP, 39, 0, 1);
        tail("t3", D1);
        consume(D1);

        frame(DA, GAP, 39, 0, 0);
        tail("t4a", DA);
        frame(DB, GAP, 39, 0, 0);
        repeat (4) @(negedge clk);
        check("t4b_ovr_pre", overrun, 0);
        @(negedge clk);
        check("t4b_ovr", overrun, 1);
        check("t4b_keep", pkt_data, DA);
        check("t4b_valid", pkt_valid, 1);
        @(negedge clk);
        check("t4b_ovr_end", overrun, 0);
        frame(DC, GAP, 39, 0, 0);
        repeat (4) @(negedge clk);
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        check("t4c_valid", pkt_valid, 1);
        check("t4c_data", pkt_data, DC);
        check("t4c_ovr", overrun, 0);
        consume(DC);

        frame(D1, GAP, 39, 20, 0);
        check("t5_busy_mid", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_rst_valid", pkt_valid, 0);
        check("t5_rst_busy", busy, 0);
        frame(D1, 0, 19, 0, 0);
        drive(1'b0, 6);
        check("t5_rest_ignored", pkt_valid, 0);
        frame(D1, GAP, 39, 0, 0);
        tail("t5", D1);
        consume(D1);

        drive(1'b1, 200);
        frame(D1, 200, 39, 0, 0);
        drive(1'b0, 6);
        check("t6_nogap_valid", pkt_valid, 0);
        check("t6_nogap_busy", busy, 0);

        check("ovr_total", ov_total, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
